// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types and constants for the slave register bank and the master BFM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi4_lite_pkg;

    // Response codes carried on BRESP/RRESP
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    // Constant returned by the last (read-only) register of the bank
    localparam logic [31:0] AXI_ID_VALUE = 32'hA411_0001;

endpackage : axi4_lite_pkg

// File: rtl/axi4_lite_regfile.sv
// Register storage: Num_Regs x Data_Width words, byte-strobed write, combinational read, flat export.
// Latency: write visible after the enabling edge; read port is combinational (returns pre-write value).
// Backpressure: none; the top decides when a write is committed.
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter int Data_Width = 32,
    parameter int Num_Regs   = 16,
    localparam int IDX_W     = $clog2(Num_Regs),
    localparam int STRB_W    = Data_Width / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr_en,
    input  logic [IDX_W-1:0]             i_wr_idx,
    input  logic [Data_Width-1:0]        i_wr_dat,
    input  logic [STRB_W-1:0]            i_wr_strb,
    input  logic [IDX_W-1:0]             i_rd_idx,
    output logic [Data_Width-1:0]        o_rd_dat,
    output logic [Num_Regs*Data_Width-1:0] o_reg_flat
);

    logic [Data_Width-1:0] w_regs [Num_Regs];

    for (genvar g = 0; g < Num_Regs; g++) begin : g_reg
        if (g == Num_Regs - 1) begin : g_id
            // Last slot is the read-only ID word; it has no storage
            assign w_regs[g] = Data_Width'(AXI_ID_VALUE);
        end else begin : g_rw
            logic [Data_Width-1:0] r_val;

            // Byte-lane update of one register when it is the commit target
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_val <= '0;
                end else if (i_wr_en && (i_wr_idx == IDX_W'(g))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (i_wr_strb[b]) begin
                            r_val[b*8 +: 8] <= i_wr_dat[b*8 +: 8];
                        end
                    end
                end
            end

            assign w_regs[g] = r_val;
        end

        assign o_reg_flat[g*Data_Width +: Data_Width] = w_regs[g];
    end

    assign o_rd_dat = w_regs[i_rd_idx];

endmodule : axi4_lite_regfile

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave terminating AW/W/B/AR/R into a memory-mapped register bank with a read-only ID word.
// Latency: write commits on the edge both AW and W are held, BVALID next cycle; AR handshake -> RVALID next cycle.
// Backpressure: one outstanding transaction per direction; AW/W/AR READY drop while a beat or response is held.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int Data_Width = 32,
    parameter int Addr_Width = 32,
    parameter int Num_Regs   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    // write address
    input  logic [Addr_Width-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    // write data
    input  logic [Data_Width-1:0]          WDATA,
    input  logic [Data_Width/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    // write response
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    // read address
    input  logic [Addr_Width-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    // read data
    output logic [Data_Width-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    // user side
    output logic [Num_Regs*Data_Width-1:0] reg_out
);

    localparam int IDX_W  = $clog2(Num_Regs);
    localparam int STRB_W = Data_Width / 8;
    localparam int ID_IDX = Num_Regs - 1;

    // channel state
    logic                  r_live;
    logic                  r_aw_full;
    logic [Addr_Width-1:0] r_aw_addr;
    logic                  r_w_full;
    logic [Data_Width-1:0] r_w_data;
    logic [STRB_W-1:0]     r_w_strb;
    logic                  r_bvalid;
    resp_t                 r_bresp;
    logic                  r_rvalid;
    logic [Data_Width-1:0] r_rdata;
    resp_t                 r_rresp;

    // handshakes and decode
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [Addr_Width-1:0] w_wr_addr;
    logic [Data_Width-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_wr_oor;
    logic                  w_wr_ok;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_rd_oor;
    logic [Data_Width-1:0] w_rd_dat;
    logic                  w_unused_addr_lsbs;

    // r_live keeps every READY low through reset and for the first edge after it
    assign AWREADY = r_live && !r_aw_full && !r_bvalid;
    assign WREADY  = r_live && !r_w_full  && !r_bvalid;
    assign ARREADY = r_live && !r_rvalid;

    assign w_aw_hs = AWVALID && AWREADY;
    assign w_w_hs  = WVALID  && WREADY;
    assign w_ar_hs = ARVALID && ARREADY;

    // A beat is available if it was latched earlier or is handshaking on this edge
    assign w_commit  = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
    assign w_wr_addr = r_aw_full ? r_aw_addr : AWADDR;
    assign w_wr_data = r_w_full  ? r_w_data  : WDATA;
    assign w_wr_strb = r_w_full  ? r_w_strb  : WSTRB;

    // Word index sits above the byte offset; any higher set bit is out of range
    assign w_wr_idx = w_wr_addr[IDX_W+1:2];
    assign w_wr_oor = |w_wr_addr[Addr_Width-1:IDX_W+2];
    assign w_wr_ok  = !w_wr_oor && (w_wr_idx != IDX_W'(ID_IDX));

    assign w_rd_idx = ARADDR[IDX_W+1:2];
    assign w_rd_oor = |ARADDR[Addr_Width-1:IDX_W+2];

    // Byte offset bits carry no meaning for word registers
    assign w_unused_addr_lsbs = &{1'b0, w_wr_addr[1:0], ARADDR[1:0]};

    // READY enable: comes up one edge after reset is released
    always_ff @(posedge clk) begin
        if (rst) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Write path: latch lone beats, commit when both present, hold B until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
        end else if (w_commit) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_ok ? OKAY : SLVERR;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= AWADDR;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= WDATA;
                r_w_strb <= WSTRB;
            end
            if (r_bvalid && BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read path: capture data on AR handshake (pre-write value on a same-edge commit)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_oor ? '0 : w_rd_dat;
            r_rresp  <= w_rd_oor ? SLVERR : OKAY;
        end else if (r_rvalid && RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    axi4_lite_regfile #(
        .Data_Width (Data_Width),
        .Num_Regs   (Num_Regs)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_commit && w_wr_ok),
        .i_wr_idx   (w_wr_idx),
        .i_wr_dat   (w_wr_data),
        .i_wr_strb  (w_wr_strb),
        .i_rd_idx   (w_rd_idx),
        .o_rd_dat   (w_rd_dat),
        .o_reg_flat (reg_out)
    );

    assign BVALID = r_bvalid;
    assign BRESP  = r_bresp;
    assign RVALID = r_rvalid;
    assign RDATA  = r_rdata;
    assign RRESP  = r_rresp;

endmodule : axi4_lite_slave_regs

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

AXI4-Lite slave that terminates the master channels of `axi4_lite_top` in a bank of memory-mapped 32-bit registers.
- Accepts write address and write data independently, applies byte strobes and returns BRESP.
- Serves reads with RRESP/RDATA.
- Exposes register contents to user logic.
- Sits directly downstream of the master BFM on the AW/W/B/AR/R channels.

## Interface
Parameters:
- `Data_Width`, 32 — data bus width; only 32 supported.
- `Addr_Width`, 32 — byte address width.
- `Num_Regs`, 16 — register count; power of two, ≥2; last index is the read-only ID register.

Ports (clock and reset):
- One clock; reset is synchronous and active-high.
- `clk` in 1 — clock; all logic on rising edge.
- `rst` in 1 — synchronous, active-high reset.

Write channels:
- `AWADDR` in Addr_Width; `AWVALID` in 1; `AWREADY` out 1 — write address channel.
- `WDATA` in Data_Width; `WSTRB` in Data_Width/8; `WVALID` in 1; `WREADY` out 1 — write data channel.
- `BRESP` out 2; `BVALID` out 1; `BREADY` in 1 — write response channel.

Read channels:
- `ARADDR` in Addr_Width; `ARVALID` in 1; `ARREADY` out 1 — read address channel.
- `RDATA` out Data_Width; `RRESP` out 2; `RVALID` out 1; `RREADY` in 1 — read data channel.

User side:
- `reg_out` out Num_Regs*Data_Width — flat register contents; reg i at bits [i*32 +: 32].

## Operation
- Decode:
  - Word index = ADDR[log2(Num_Regs)+1:2]; ADDR[1:0] ignored.
  - Any set bit in ADDR[Addr_Width-1:log2(Num_Regs)+2] = out of range.
- Write path: `aw_full` and `w_full` flags each hold one latched beat.
  - `AWREADY` = !aw_full && !BVALID.
  - `WREADY` = !w_full && !BVALID.
  - Commit occurs on the edge where both beats are available: latched or handshaking that edge, including simultaneously.
  - Commit with in-range address, not ID index:
    - Reg bytes updated where `WSTRB` bit set.
    - BRESP=OKAY (2'b00).
  - Commit with out-of-range address or ID index:
    - No register change.
    - BRESP=SLVERR (2'b10).
  - At commit: BVALID←1; both flags cleared.
  - BVALID held with stable BRESP until BVALID&&BREADY, then cleared.
- Read path: `ARREADY` = !RVALID.
  - On AR handshake, RVALID←1 and RDATA/RRESP are latched:
    - In-range address: register value (ID reg returns ID constant), RRESP=OKAY.
    - Out-of-range address: RDATA=0, RRESP=SLVERR.
  - RDATA/RRESP held stable until RVALID&&RREADY.
- Read and write paths are fully independent. One outstanding transaction per direction.

## Timing
- Reset values:
  - AWREADY, WREADY, ARREADY = 0 during `rst`; they become 1 the cycle after `rst` deasserts.
  - BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
  - All registers 0 except ID = 32'hA411_0001.
  - Flags cleared.
- Write latency: AW and W handshake at edge N → register updated and BVALID=1 after edge N; earliest BREADY completion at edge N+1.
- Split write: AW at edge N, W at edge M>N → commit at edge M. AWREADY stays 0 from after N until BVALID completes. The W-first case is symmetric.
- Back-to-back writes: the next AW/W handshake is possible on the edge after the B handshake. One idle cycle between bursts is required.
- Read latency: AR handshake at edge N → RVALID=1 after edge N. With RREADY held high, one read completes every 2 cycles.
- Read/write collision: AR handshake and write commit to the same register on the same edge → RDATA returns the pre-write value.
- Slave never deasserts VALID without a handshake. It ignores master VALID deassertion on unlatched beats (legal only for non-compliant masters; no recovery).
- `rst` asserted mid-transaction:
  - Latched beats and pending B/R responses are dropped.
  - Registers return to reset values on that edge.

## Structure
- Package `axi4_lite_pkg`:
  - `resp_t` enum (OKAY=2'b00, SLVERR=2'b10).
  - `AXI_ID_VALUE` = 32'hA411_0001.
  - Shared with master BFM.
- Sub-module `axi4_lite_regfile`:
  - Num_Regs×32 storage, byte-strobed write port, combinational read port, flat `reg_out`.
  - The top handles the channel flags, decode and response logic.

## Test plan
- Reset → all READY 0 during `rst`, 1 next cycle; B/R VALID 0; reading 0x3C returns 32'hA411_0001, OKAY.
- AW=0x04 and W=32'h1234_5678, strobe 4'hF, same cycle → BVALID next cycle, BRESP=OKAY; read 0x04 → 32'h1234_5678.
- W first (data 32'hFFFF_FFFF, strobe 4'b0101), AW=0x08 three cycles later, reg preloaded 0:
  - AWREADY/WREADY behave as specified.
  - Read 0x08 → 32'h00FF_00FF.
- Write 0x40 (out of range) and write 0x3C (ID) → both BRESP=SLVERR, no register changes; read 0x40 → RDATA 0, SLVERR.
- BREADY/RREADY held low 5 cycles → BVALID/RVALID, BRESP/RDATA stable; AWREADY/ARREADY stay 0 until handshake.
- Write 0x0C=32'hAAAA_AAAA over old 32'h5555_5555, with read of 0x0C on the same commit edge → RDATA=32'h5555_5555; later read → 32'hAAAA_AAAA.
